// File: rtl/jam_search_param.sv
// rtl/jam_search_param.sv - exhaustive N x N job-assignment search with min/max mode
module jam_search_param #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int IDX_W  = 3,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              mode,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost,
    output logic              busy,
    output logic [CNT_W-1:0]  MatchCount,
    output logic [SUM_W-1:0]  MinCost,
    output logic              Valid
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACC, S_UPD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic              first_q, first_d;
    logic [IDX_W-1:0]  w_q, w_d, j_q, j_d, idx_q, idx_d;
    logic [SUM_W-1:0]  sum_q, sum_d, best_q, best_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d, busy_q, busy_d;
    logic [COST_W-1:0] arr_q [N][DEPTH];
    logic [COST_W-1:0] arr_d [N][DEPTH];
    logic [IDX_W-1:0]  perm_q [N];
    logic [IDX_W-1:0]  perm_d [N];

    logic [COST_W-1:0] term;
    int                piv_i, succ_i;
    logic              found;
    logic [IDX_W-1:0]  piv_val, succ_val;
    logic [IDX_W-1:0]  tmp_perm [N];
    logic [IDX_W-1:0]  nxt_perm [N];
    logic              better, equal;

    always_comb begin
        term = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) term = arr_q[i][perm_q[i]];
        end
    end

    // Next lexicographic permutation; the suffix right of the pivot is descending,
    // so the last larger element is the smallest one exceeding the pivot.
    always_comb begin
        found = 1'b0;
        piv_i = 0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm_q[i] < perm_q[i+1]) begin
                found = 1'b1;
                piv_i = i;
            end
        end
        piv_val = '0;
        for (int i = 0; i < N; i++) begin
            if (i == piv_i) piv_val = perm_q[i];
        end
        succ_i = N - 1;
        for (int k = 0; k < N; k++) begin
            if (k > piv_i && perm_q[k] > piv_val) succ_i = k;
        end
        succ_val = '0;
        for (int k = 0; k < N; k++) begin
            if (k == succ_i) succ_val = perm_q[k];
        end
        for (int k = 0; k < N; k++) begin
            tmp_perm[k] = perm_q[k];
            if (k == piv_i) tmp_perm[k] = succ_val;
            if (k == succ_i) tmp_perm[k] = piv_val;
        end
        for (int k = 0; k < N; k++) begin
            nxt_perm[k] = tmp_perm[k];
            for (int m = 0; m < N; m++) begin
                if (k > piv_i && m == N + piv_i - k) nxt_perm[k] = tmp_perm[m];
            end
        end
    end

    assign better = mode_q ? (sum_q > best_q) : (sum_q < best_q);
    assign equal  = (sum_q == best_q);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        first_d = first_q;
        w_d     = w_q;
        j_d     = j_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        best_d  = best_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        arr_d   = arr_q;
        perm_d  = perm_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    first_d = 1'b1;
                    w_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < N; i++) begin
                    if (w_q == IDX_W'(i)) arr_d[i][j_q] = Cost;
                end
                if (j_q == IDX_W'(N - 1)) begin
                    if (w_q == IDX_W'(N - 1)) begin
                        for (int i = 0; i < N; i++) perm_d[i] = IDX_W'(i);
                        sum_d   = '0;
                        idx_d   = '0;
                        state_d = S_ACC;
                    end else begin
                        w_d = w_q + IDX_W'(1);
                        j_d = '0;
                    end
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            S_ACC: begin
                sum_d = sum_q + SUM_W'(term);
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d   = '0;
                    state_d = S_UPD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_UPD: begin
                first_d = 1'b0;
                if (first_q || better) begin
                    best_d = sum_q;
                    cnt_d  = CNT_W'(1);
                end else if (equal && cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (found) begin
                    perm_d  = nxt_perm;
                    sum_d   = '0;
                    state_d = S_ACC;
                end else begin
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            first_q <= 1'b0;
            w_q     <= '0;
            j_q     <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            best_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                perm_q[i] <= '0;
                for (int k = 0; k < DEPTH; k++) arr_q[i][k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            first_q <= first_d;
            w_q     <= w_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            best_q  <= best_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            arr_q   <= arr_d;
            perm_q  <= perm_d;
        end
    end

    assign W          = w_q;
    assign J          = j_q;
    assign busy       = busy_q;
    assign MatchCount = cnt_q;
    assign MinCost    = best_q;
    assign Valid      = valid_q;
endmodule

// File: tb/tb_jam_search_param.sv
// tb/tb_jam_search_param.sv - scoreboard bench for jam_search_param (N=3, saturating CNT_W=2)
module tb_jam_search_param;
    localparam int N      = 3;
    localparam int COST_W = 7;
    localparam int IDX_W  = 2;
    localparam int SUM_W  = 9;
    localparam int CNT_W  = 2;
    localparam int LAT    = 34;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [IDX_W-1:0]  W, J;
    logic [COST_W-1:0] Cost;
    logic              busy, Valid;
    logic [CNT_W-1:0]  MatchCount;
    logic [SUM_W-1:0]  MinCost;

    logic [COST_W-1:0] mat [4][4];
    assign Cost = mat[W][J];

    jam_search_param #(.N(N), .COST_W(COST_W), .IDX_W(IDX_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .mode(mode), .W(W), .J(J), .Cost(Cost),
        .busy(busy), .MatchCount(MatchCount), .MinCost(MinCost), .Valid(Valid)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        int best;
        int cnt;
        int vcyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int last_best = 0;
    int last_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: try every N-digit tuple, keep the ones that are permutations.
    function automatic void model(input logic m, output int best, output int cnt);
        int d [N];
        int p, s;
        bit ok, have;
        have = 0;
        best = 0;
        cnt = 0;
        for (int t = 0; t < N**N; t++) begin
            p = t;
            for (int i = 0; i < N; i++) begin
                d[i] = p % N;
                p = p / N;
            end
            ok = 1;
            for (int i = 0; i < N; i++)
                for (int k = i + 1; k < N; k++)
                    if (d[i] == d[k]) ok = 0;
            if (ok) begin
                s = 0;
                for (int i = 0; i < N; i++) s += int'(mat[i][d[i]]);
                if (!have || (m ? s > best : s < best)) begin
                    best = s;
                    cnt = 1;
                    have = 1;
                end else if (s == best) begin
                    cnt++;
                end
            end
        end
        if (cnt > CMAX) cnt = CMAX;
    endfunction

    always @(negedge CLK) begin
        if (Valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("min_cost", int'(MinCost), e.best);
                chk("match_count", int'(MatchCount), e.cnt);
                chk("valid_cycle", cyc, e.vcyc);
                chk("busy_at_valid", int'(busy), 1);
            end
        end
    end

    task automatic load_mat(input int kind);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                case (kind)
                    0: mat[i][k] = COST_W'((i + 1) * (k + 1));
                    1: mat[i][k] = 7'd127;
                    2: mat[i][k] = 7'd5;
                    3: mat[i][k] = COST_W'($urandom_range(0, 3));
                    default: mat[i][k] = COST_W'($urandom_range(0, 127));
                endcase
            end
    endtask

    task automatic run_search(input logic m, input bit pulse_busy);
        exp_t e;
        int c0;
        bit done;
        model(m, e.best, e.cnt);
        @(negedge CLK);
        start = 1'b1;
        mode = m;
        @(posedge CLK);
        #1;
        start = 1'b0;
        mode = ~m;
        c0 = cyc;
        e.vcyc = c0 + LAT - 1;
        sb.push_back(e);
        chk("busy_after_start", int'(busy), 1);
        for (int k = 0; k < N * N; k++) begin
            chk("wj_sweep", int'({W, J}), ((k / N) << IDX_W) | (k % N));
            if (k == 5) begin
                chk("hold_min", int'(MinCost), last_best);
                chk("hold_cnt", int'(MatchCount), last_cnt);
            end
            if (pulse_busy && k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            @(posedge CLK);
            #1;
        end
        done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            if (!busy) done = 1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        chk("search_finished", int'(done), 1);
        chk("scoreboard_drained", sb.size(), 0);
        chk("idle_wj_hold", int'({W, J}), ((N - 1) << IDX_W) | (N - 1));
        sb.delete();
        last_best = e.best;
        last_cnt = e.cnt;
    endtask

    initial begin
        load_mat(0);
        #2;
        chk("rst_w", int'(W), 0);
        chk("rst_j", int'(J), 0);
        chk("rst_min", int'(MinCost), 0);
        chk("rst_cnt", int'(MatchCount), 0);
        chk("rst_valid", int'(Valid), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        load_mat(0);
        run_search(1'b0, 0);
        chk("spec_min_value", last_best, 10);
        run_search(1'b1, 0);
        chk("spec_max_value", last_best, 14);
        load_mat(1);
        run_search(1'b1, 0);
        chk("all127_max", last_best, 381);
        chk("all127_sat", last_cnt, CMAX);
        load_mat(2);
        run_search(1'b0, 1);
        chk("all5_min", last_best, 15);

        for (int r = 0; r < 24; r++) begin
            load_mat(3 + (r % 2));
            run_search(1'($urandom_range(0, 1)), r % 3 == 0);
        end

        load_mat(0);
        @(negedge CLK);
        start = 1'b1;
        mode = 1'b0;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (12) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("midrst_w", int'(W), 0);
        chk("midrst_j", int'(J), 0);
        chk("midrst_min", int'(MinCost), 0);
        chk("midrst_cnt", int'(MatchCount), 0);
        chk("midrst_valid", int'(Valid), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("start_in_reset_ignored", int'(busy), 0);
        last_best = 0;
        last_cnt = 0;
        run_search(1'b0, 0);
        chk("post_reset_min", last_best, 10);

        repeat (40) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
